reg_status_writer: RTL and testbench

//  Write side of the 7-entry architectural register bank (R1..R7) for the Tomasulo core.

---
 rtl/reg_status_writer.sv | 102 ++++++++++
 tb/tb_reg_status_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_status_writer.sv
// rtl/reg_status_writer.sv - write side of the R1..R7 register bank with busy/producer-tag status
// Issue renames, CDB results retire matching producers, loads write directly; err flags illegal requests.
module reg_status_writer #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [2:0]        issue_rd,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              ld_valid,
  input  logic [2:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [2:0]        qry_addr,
  output logic              qry_busy,
  output logic [TAG_W-1:0]  qry_tag,
  output logic [6:0]        busy,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] R3,
  output logic [DATA_W-1:0] R4,
  output logic [DATA_W-1:0] R5,
  output logic [DATA_W-1:0] R6,
  output logic [DATA_W-1:0] R7,
  output logic              err
);

  // Entry k holds register R(k+1); address 0 has no storage.
  logic [DATA_W-1:0] regs [7];
  logic [TAG_W-1:0]  tags [7];
  logic [6:0]        busy_q;

  logic [6:0] cdb_hit;
  logic [6:0] iss_hit;
  logic [6:0] ld_hit;
  logic       illegal;

  always_comb begin
    cdb_hit = '0;
    iss_hit = '0;
    ld_hit  = '0;
    for (int k = 0; k < 7; k++) begin
      cdb_hit[k] = cdb_valid && (cdb_tag != '0) && busy_q[k] && (tags[k] == cdb_tag);
      iss_hit[k] = issue_valid && (issue_tag != '0) && (issue_rd == 3'(k + 1));
      ld_hit[k]  = ld_valid && (ld_addr == 3'(k + 1));
    end
    illegal = (issue_valid && ((issue_rd == 3'd0) || (issue_tag == '0)))
            || (ld_valid && (ld_addr == 3'd0));
  end

  // Data: CDB beats load. Status: issue beats CDB beats load, so a same-cycle
  // retire+rename leaves the register pending on the newer producer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 7; k++) begin
        regs[k] <= '0;
        tags[k] <= '0;
      end
      busy_q <= '0;
      err    <= 1'b0;
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (cdb_hit[k])
          regs[k] <= cdb_data;
        else if (ld_hit[k])
          regs[k] <= ld_data;

        if (iss_hit[k]) begin
          busy_q[k] <= 1'b1;
          tags[k]   <= issue_tag;
        end else if (cdb_hit[k] || ld_hit[k]) begin
          busy_q[k] <= 1'b0;
          tags[k]   <= '0;
        end
      end
      err <= illegal;
    end
  end

  always_comb begin
    qry_busy = 1'b0;
    qry_tag  = '0;
    if (qry_addr != 3'd0) begin
      qry_busy = busy_q[qry_addr - 3'd1];
      qry_tag  = tags[qry_addr - 3'd1];
    end
  end

  assign busy = busy_q;
  assign R1   = regs[0];
  assign R2   = regs[1];
  assign R3   = regs[2];
  assign R4   = regs[3];
  assign R5   = regs[4];
  assign R6   = regs[5];
  assign R7   = regs[6];

endmodule

// File: tb/tb_reg_status_writer.sv
// tb/tb_reg_status_writer.sv - directed self-checking bench for reg_status_writer
// Linear directed steps; every expected value is hand-computed.
module tb_reg_status_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic [2:0]  issue_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  qry_addr;
  logic        qry_busy;
  logic [2:0]  qry_tag;
  logic [6:0]  busy;
  logic [15:0] R1, R2, R3, R4, R5, R6, R7;
  logic        err;

  int compared = 0;
  int mismatched = 0;

  reg_status_writer #(.DATA_W(16), .TAG_W(3)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .qry_addr(qry_addr), .qry_busy(qry_busy), .qry_tag(qry_tag),
    .busy(busy),
    .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
    .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = 3'd0; issue_tag = 3'd0;
    cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 16'h0;
    ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 16'h0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_issue(input logic [2:0] rd, input logic [2:0] tg);
    issue_valid = 1'b1; issue_rd = rd; issue_tag = tg;
  endtask

  task automatic do_cdb(input logic [2:0] tg, input logic [15:0] d);
    cdb_valid = 1'b1; cdb_tag = tg; cdb_data = d;
  endtask

  task automatic do_ld(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
  endtask

  initial begin
    idle();
    qry_addr = 3'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", busy, 7'b0);
    check("reset_err", err, 1'b0);

    // Test 1: R3=0x1234 busy with err pending, then async reset mid-cycle
    do_ld(3'd3, 16'h1234);
    tick(); idle();
    do_issue(3'd3, 3'd5); do_ld(3'd0, 16'hFFFF);
    tick(); idle();
    check("t1_r3_pre", R3, 16'h1234);
    check("t1_busy_pre", busy, 7'b0000100);
    check("t1_err_pre", err, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t1_r3_rst", R3, 16'h0);
    check("t1_busy_rst", busy, 7'b0);
    check("t1_err_rst", err, 1'b0);
    qry_addr = 3'd3;
    #1;
    check("t1_qry_tag_rst", qry_tag, 3'd0);
    tick();
    reset = 1'b0;

    // Test 2: load then rename
    do_ld(3'd5, 16'hBEEF);
    tick(); idle();
    do_issue(3'd5, 3'd2);
    tick(); idle();
    qry_addr = 3'd5;
    #1;
    check("t2_r5", R5, 16'hBEEF);
    check("t2_busy", busy, 7'b0010000);
    check("t2_qry_busy", qry_busy, 1'b1);
    check("t2_qry_tag", qry_tag, 3'd2);
    qry_addr = 3'd0;
    #1;
    check("t2_qry0", {qry_busy, qry_tag}, 4'b0);

    // Test 3: CDB retire, then repeated broadcast with no match
    do_cdb(3'd2, 16'h0042);
    tick(); idle();
    check("t3_r5", R5, 16'h0042);
    check("t3_busy", busy, 7'b0);
    do_cdb(3'd2, 16'h0099);
    tick(); idle();
    check("t3_r5_again", R5, 16'h0042);
    check("t3_err", err, 1'b0);

    // Test 4: two registers waiting on the same tag
    do_issue(3'd2, 3'd4);
    tick(); idle();
    do_issue(3'd6, 3'd4);
    tick(); idle();
    check("t4_busy_pre", busy, 7'b0100010);
    do_cdb(3'd4, 16'h00AA);
    tick(); idle();
    check("t4_r2", R2, 16'h00AA);
    check("t4_r6", R6, 16'h00AA);
    check("t4_busy", busy, 7'b0);

    // Test 5: retire and rename same register in the same cycle
    do_issue(3'd1, 3'd1);
    tick(); idle();
    do_cdb(3'd1, 16'h0007); do_issue(3'd1, 3'd3);
    tick(); idle();
    qry_addr = 3'd1;
    #1;
    check("t5_r1", R1, 16'h0007);
    check("t5_busy", busy, 7'b0000001);
    check("t5_qry_tag", qry_tag, 3'd3);

    // Issue + load to same register: load data, pending on issue tag
    do_issue(3'd7, 3'd6); do_ld(3'd7, 16'h5555);
    tick(); idle();
    qry_addr = 3'd7;
    #1;
    check("il_r7", R7, 16'h5555);
    check("il_busy", busy, 7'b1000001);
    check("il_qry_tag", qry_tag, 3'd6);

    // CDB + load to same register: CDB data wins, not busy
    do_cdb(3'd6, 16'h1111); do_ld(3'd7, 16'h2222);
    tick(); idle();
    check("cl_r7", R7, 16'h1111);
    check("cl_busy", busy, 7'b0000001);

    // cdb_tag=0 is ignored without err
    do_cdb(3'd0, 16'hDEAD);
    tick(); idle();
    check("cdb0_r1", R1, 16'h0007);
    check("cdb0_busy", busy, 7'b0000001);
    check("cdb0_err", err, 1'b0);

    // Independent requests to different registers in one cycle
    do_ld(3'd4, 16'h4444); do_issue(3'd3, 3'd2); do_cdb(3'd3, 16'h3333);
    tick(); idle();
    check("ind_r4", R4, 16'h4444);
    check("ind_r1", R1, 16'h3333);
    check("ind_busy", busy, 7'b0000100);

    // Test 6: illegal issues pulse err for one cycle each, status untouched
    do_issue(3'd0, 3'd1);
    tick(); idle();
    check("t6_err_rd0", err, 1'b1);
    check("t6_busy_rd0", busy, 7'b0000100);
    tick();
    check("t6_err_clr1", err, 1'b0);
    do_issue(3'd4, 3'd0);
    tick(); idle();
    check("t6_err_tag0", err, 1'b1);
    check("t6_busy_tag0", busy, 7'b0000100);
    check("t6_r4", R4, 16'h4444);
    tick();
    check("t6_err_clr2", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
